fsincos_arb: RTL

Round-robin request scheduler that shares one fsincos pipeline (the `top` datapath) among `NUM_REQ` requesters. It issues at most one operand per cycle into the pipeline and tags each issue with its requester ID. It buffers in-order pipeline results in a result FIFO and returns each result, with its ID, on a valid/ready port. Issue is credit-limited, so the result FIFO can never overflow; the pipeline itself has no backpressure.

---
 rtl/fsincos_arb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fsincos_arb.sv
// fsincos_arb: round-robin scheduler sharing one fsincos pipeline among NUM_REQ requesters.
// Define FSINCOS_ARB_PRIO_EN to give requester 0 strict priority over the round-robin.
module fsincos_arb #(
    parameter int NUM_REQ    = 4,
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
    localparam int PW   = $clog2(FIFO_DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ-1:0]            i_req_sign,
    input  logic [NUM_REQ*EXP_WIDTH-1:0]  i_req_exp,
    input  logic [NUM_REQ*FRAC_WIDTH-1:0] i_req_frac,
    input  logic [NUM_REQ-1:0]            i_req_sincos,
    output logic                          o_pl_valid,
    output logic                          o_pl_sign,
    output logic [EXP_WIDTH-1:0]          o_pl_exp,
    output logic [FRAC_WIDTH-1:0]         o_pl_frac,
    output logic                          o_pl_sincos,
    input  logic                          i_pl_valid,
    input  logic                          i_pl_sign,
    input  logic [EXP_WIDTH-1:0]          i_pl_exp,
    input  logic [FRAC_WIDTH-1:0]         i_pl_frac,
    input  logic                          i_pl_sincos,
    output logic                          o_res_valid,
    input  logic                          i_res_ready,
    output logic [ID_W-1:0]               o_res_id,
    output logic                          o_res_sign,
    output logic [EXP_WIDTH-1:0]          o_res_exp,
    output logic [FRAC_WIDTH-1:0]         o_res_frac,
    output logic                          o_res_sincos,
    output logic [CW-1:0]                 o_outstanding,
    output logic                          o_busy,
    output logic                          o_err_orphan
);
    localparam int RW = ID_W + EXP_WIDTH + FRAC_WIDTH + 2;

    logic [CW-1:0]   out_q, out_d;
    logic [ID_W-1:0] rr_q, rr_d, rr_nxt, gnt_id, cand;
    logic            gnt_any, can_issue, issue;
    logic            pl_valid_q, pl_sign_q, pl_sincos_q;
    logic [EXP_WIDTH-1:0]  pl_exp_q;
    logic [FRAC_WIDTH-1:0] pl_frac_q;
    logic            orphan_q;

    logic [ID_W-1:0] tag_mem [FIFO_DEPTH];
    logic [PW-1:0]   tag_wr_q, tag_rd_q;
    logic [CW-1:0]   tag_cnt_q;
    logic            tag_pop;

    logic [RW-1:0]   res_mem [FIFO_DEPTH];
    logic [PW-1:0]   res_wr_q, res_rd_q, res_rd_d;
    logic [CW-1:0]   res_cnt_q, res_cnt_d;
    logic [RW-1:0]   res_in, res_q, res_d;
    logic            res_valid_q, res_push, res_pop;

    assign can_issue = out_q < CW'(FIFO_DEPTH);

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        if (can_issue && !i_rst) begin
`ifdef FSINCOS_ARB_PRIO_EN
            gnt_any = i_req_valid[0];
`endif
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = ID_W'((int'(rr_q) + i) % NUM_REQ);
                if (!gnt_any && i_req_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_id  = cand;
                end
            end
        end
    end

    assign issue       = gnt_any;
    assign o_req_ready = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;
    assign rr_nxt      = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
`ifdef FSINCOS_ARB_PRIO_EN
    assign rr_d        = (issue && gnt_id != '0) ? rr_nxt : rr_q;
`else
    assign rr_d        = issue ? rr_nxt : rr_q;
`endif

    // Pipeline results are in issue order, so the oldest tag owns each result.
    assign tag_pop  = i_pl_valid && tag_cnt_q != '0;
    assign res_in   = {tag_mem[tag_rd_q], i_pl_sign, i_pl_exp, i_pl_frac, i_pl_sincos};
    assign res_pop  = res_valid_q && i_res_ready;
    assign res_push = tag_pop && (res_cnt_q != CW'(FIFO_DEPTH) || res_pop);
    assign res_rd_d = res_rd_q + PW'(res_pop);
    assign res_cnt_d = res_cnt_q + CW'(res_push) - CW'(res_pop);
    // The output register tracks the post-update head so results stay registered and hold when empty.
    assign res_d = (res_cnt_d == '0) ? res_q
                 : (res_cnt_q - CW'(res_pop) == '0) ? res_in : res_mem[res_rd_d];
    assign out_d = out_q + CW'(issue) - CW'(res_pop);

    always_ff @(posedge i_clk) begin
        if (issue)
            tag_mem[tag_wr_q] <= gnt_id;
        if (res_push)
            res_mem[res_wr_q] <= res_in;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q       <= '0;
            rr_q        <= '0;
            pl_valid_q  <= 1'b0;
            pl_sign_q   <= 1'b0;
            pl_exp_q    <= '0;
            pl_frac_q   <= '0;
            pl_sincos_q <= 1'b0;
            orphan_q    <= 1'b0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
            tag_cnt_q   <= '0;
            res_wr_q    <= '0;
            res_rd_q    <= '0;
            res_cnt_q   <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            rr_q        <= rr_d;
            pl_valid_q  <= issue;
            if (issue) begin
                pl_sign_q   <= i_req_sign[gnt_id];
                pl_exp_q    <= i_req_exp[int'(gnt_id)*EXP_WIDTH +: EXP_WIDTH];
                pl_frac_q   <= i_req_frac[int'(gnt_id)*FRAC_WIDTH +: FRAC_WIDTH];
                pl_sincos_q <= i_req_sincos[gnt_id];
            end
            orphan_q    <= orphan_q || (i_pl_valid && tag_cnt_q == '0);
            tag_wr_q    <= tag_wr_q + PW'(issue);
            tag_rd_q    <= tag_rd_q + PW'(tag_pop);
            tag_cnt_q   <= tag_cnt_q + CW'(issue) - CW'(tag_pop);
            res_wr_q    <= res_wr_q + PW'(res_push);
            res_rd_q    <= res_rd_d;
            res_cnt_q   <= res_cnt_d;
            res_q       <= res_d;
            res_valid_q <= res_cnt_d != '0;
        end
    end

    assign o_pl_valid    = pl_valid_q;
    assign o_pl_sign     = pl_sign_q;
    assign o_pl_exp      = pl_exp_q;
    assign o_pl_frac     = pl_frac_q;
    assign o_pl_sincos   = pl_sincos_q;
    assign o_res_valid   = res_valid_q;
    assign {o_res_id, o_res_sign, o_res_exp, o_res_frac, o_res_sincos} = res_q;
    assign o_outstanding = out_q;
    assign o_busy        = out_q != '0;
    assign o_err_orphan  = orphan_q;
endmodule
